core_id_reader: RTL and testbench
=================================

CORE_ID_READER -- requirements
Module: core_id_reader

Interface
REQ-001 The block SHALL have parameter REG_ADDR, default 8'hFF: register-bus address of the core-ID text register.
REQ-002 The block SHALL have parameter RD_CYCLES, default 2: read-strobe high time per byte, legal range 1..15.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2: read-strobe low time between bytes, legal range 1..15.
REQ-004 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port start  input  1  one-cycle request to fetch the ID string.
REQ-007 The block SHALL have port busy  output  1  high while a fetch is in progress.
REQ-008 The block SHALL have port done  output  1  high from fetch end until next accepted start or rst.
REQ-009 The block SHALL have port error  output  1  high with done when the fetch was aborted.
REQ-010 The block SHALL have port zxuno_addr  output  8  register address driven to the bus.
REQ-011 The block SHALL have port zxuno_regrd  output  1  register read strobe.
REQ-012 The block SHALL have port regaddr_changed  output  1  one-cycle address-select pulse.
REQ-013 The block SHALL have port din  input  8  read data from the ID register.
REQ-014 The block SHALL have port din_oe_n  input  1  ID register output enable, active-low.
REQ-015 The block SHALL have port len  output  5  number of stored characters, 0..16.
REQ-016 The block SHALL have port buf_addr  input  4  character buffer read index.
REQ-017 The block SHALL have port buf_data  output  8  character at buf_addr, registered.

Function
REQ-018 The FSM SHALL have states IDLE, SELECT, READ, GAP and DONE; IDLE or DONE with start=1 SHALL move to SELECT; start in any other state SHALL be ignored.
REQ-019 On entering SELECT, len SHALL clear to 0 and done and error SHALL clear to 0.
REQ-020 In SELECT (one cycle), zxuno_addr SHALL be REG_ADDR and regaddr_changed SHALL be 1; the next state SHALL be READ.
REQ-021 In READ, zxuno_addr SHALL be REG_ADDR and zxuno_regrd SHALL be 1 for exactly RD_CYCLES cycles; din SHALL be sampled on the last READ cycle.
REQ-022 In GAP, zxuno_regrd SHALL be 0 and zxuno_addr SHALL be REG_ADDR for exactly GAP_CYCLES cycles, then the FSM SHALL return to READ.
REQ-023 A sampled byte of 8'h00 SHALL terminate the fetch: the byte is not stored, and the FSM goes directly to DONE with no GAP.
REQ-024 A sampled non-zero byte SHALL be written to buf[len] and len SHALL increment; if len becomes 16, the FSM SHALL go directly to DONE, otherwise to GAP.
REQ-025 If din_oe_n is 1 in any READ cycle, the FSM SHALL go to DONE with error=1; len SHALL keep the count stored so far, and the current byte SHALL be discarded.
REQ-026 Outside SELECT, READ and GAP, zxuno_addr SHALL be 8'h00 and zxuno_regrd and regaddr_changed SHALL be 0.
REQ-027 busy SHALL be 1 exactly in SELECT, READ and GAP; done SHALL be 1 exactly in DONE.
REQ-028 buf_data SHALL equal buf[buf_addr] one cycle after buf_addr is presented, and SHALL be 8'h00 when buf_addr >= len.
REQ-029 With defaults, byte i SHALL be read in cycles 2+4i and 3+4i after the cycle start is sampled, and DONE SHALL begin one cycle after the terminating READ.
REQ-030 The READ/GAP timer SHALL be 4 bits wide and SHALL reload on every state entry; len SHALL saturate at 16.

Reset
REQ-031 With rst=1 at a clock edge, the FSM SHALL go to IDLE and busy, done, error, zxuno_regrd and regaddr_changed SHALL be 0.
REQ-032 With rst=1 at a clock edge, zxuno_addr SHALL be 8'h00, len SHALL be 0 and buf_data SHALL be 8'h00.
REQ-033 rst SHALL take priority over start, and rst during a fetch SHALL abort it immediately with no further bus activity.
REQ-034 Buffer contents need not be cleared by rst, because the len gating of REQ-028 applies.

Verification
REQ-035 The bench SHALL model a responder holding "T20-07122015" followed by 8'h00, pulse start once and check: done at cycle 52, len=12, buf[0]=8'h54, buf[11]=8'h35, buf[12]=8'h00, error=0.
REQ-036 The bench SHALL use a responder with 16 non-zero bytes 8'h41..8'h50 and check: done at cycle 64, len=16, buf[15]=8'h50, and no 17th strobe.
REQ-037 The bench SHALL use a responder whose first byte is 8'h00 and check: done at cycle 4, len=0, and buf_data=8'h00 for all buf_addr.
REQ-038 The bench SHALL force din_oe_n=1 during the READ of byte 3 and check: done=1, error=1, len=3.
REQ-039 The bench SHALL pulse start again while busy and check it is ignored; the bench SHALL assert rst at cycle 20 and check IDLE on the next cycle with all outputs at reset values.
REQ-040 The bench SHALL start a second fetch from DONE and check that len and error clear in SELECT and that regaddr_changed pulses exactly once.

Source files
------------

// File: rtl/core_id_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_reader_if
//  Description : Register-bus link between the core-ID reader and the ID
//                register responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_id_reader_if;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       regaddr_changed;
    logic [7:0] din;
    logic       din_oe_n;

    modport master (
        output zxuno_addr,
        output zxuno_regrd,
        output regaddr_changed,
        input  din,
        input  din_oe_n
    );

    modport slave (
        input  zxuno_addr,
        input  zxuno_regrd,
        input  regaddr_changed,
        output din,
        output din_oe_n
    );
endinterface
`default_nettype wire

// File: rtl/core_id_reader.sv
`default_nettype none
// ============================================================================
//  Module      : core_id_reader
//  Description : Fetches the zero-terminated core-ID string from a register
//                bus into a 16-character buffer with indexed read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_id_reader #(
    parameter logic [7:0]  REG_ADDR   = 8'hFF,
    parameter int unsigned RD_CYCLES  = 2,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [4:0]       len,
    input  wire  [3:0]       buf_addr,
    output logic [7:0]       buf_data,
    core_id_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        READ   = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] c_rd_reload  = 4'(RD_CYCLES - 1);
    localparam logic [3:0] c_gap_reload = 4'(GAP_CYCLES - 1);
    localparam logic [4:0] c_max_len    = 5'd16;

    state_t     r_state;
    logic [3:0] r_timer;
    logic [4:0] r_len;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic [7:0] r_addr;
    logic       r_regrd;
    logic       r_sel;
    logic [7:0] r_mem [16];
    logic [7:0] r_buf_data;

    logic w_last_rd;
    logic w_abort;
    logic w_store;
    logic w_finish;

    // Abort wins over the data byte; a full buffer ends the fetch without a gap.
    always_comb begin
        w_last_rd = (r_state == READ) && (r_timer == 4'd0);
        w_abort   = (r_state == READ) && bus.din_oe_n;
        w_store   = w_last_rd && !bus.din_oe_n && (bus.din != 8'h00) && (r_len < c_max_len);
        w_finish  = w_abort ||
                    (w_last_rd && ((bus.din == 8'h00) || (r_len == c_max_len - 5'd1)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= 4'd0;
            r_len   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_addr  <= 8'h00;
            r_regrd <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= SELECT;
                        r_len   <= 5'd0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_addr  <= REG_ADDR;
                        r_sel   <= 1'b1;
                        r_regrd <= 1'b0;
                    end
                end
                SELECT: begin
                    r_state <= READ;
                    r_timer <= c_rd_reload;
                    r_sel   <= 1'b0;
                    r_regrd <= 1'b1;
                end
                READ: begin
                    if (w_finish) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_error <= w_abort;
                        r_addr  <= 8'h00;
                        r_regrd <= 1'b0;
                    end else if (w_last_rd) begin
                        r_state <= GAP;
                        r_timer <= c_gap_reload;
                        r_regrd <= 1'b0;
                    end else begin
                        r_timer <= r_timer - 4'd1;
                    end
                    if (w_store) begin
                        r_len <= r_len + 5'd1;
                    end
                end
                GAP: begin
                    if (r_timer == 4'd0) begin
                        r_state <= READ;
                        r_timer <= c_rd_reload;
                        r_regrd <= 1'b1;
                    end else begin
                        r_timer <= r_timer - 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_addr  <= 8'h00;
                    r_regrd <= 1'b0;
                    r_sel   <= 1'b0;
                end
            endcase
        end
    end

    // Buffer storage is never cleared; len gates stale characters on read-back.
    always_ff @(posedge clk) begin
        if (w_store && !rst) begin
            r_mem[r_len[3:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_data <= 8'h00;
        end else if ({1'b0, buf_addr} < r_len) begin
            r_buf_data <= r_mem[buf_addr];
        end else begin
            r_buf_data <= 8'h00;
        end
    end

    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign len                 = r_len;
    assign buf_data            = r_buf_data;
    assign bus.zxuno_addr      = r_addr;
    assign bus.zxuno_regrd     = r_regrd;
    assign bus.regaddr_changed = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_core_id_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_id_reader
//  Description : Self-checking bench for core_id_reader with a modelled ID
//                register responder and a scoreboard of expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_id_reader;

    localparam logic [7:0] c_reg_addr = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] len;
    logic [3:0] buf_addr;
    logic [7:0] buf_data;
    logic       oe_n;

    core_id_reader_if bus ();

    core_id_reader #(
        .REG_ADDR   (c_reg_addr),
        .RD_CYCLES  (2),
        .GAP_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .len      (len),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .bus      (bus.master)
    );

    always #5 clk = ~clk;

    // Responder: byte pointer restarts on address select, advances at each strobe end.
    logic [7:0] resp [32];
    int         resp_idx = 0;
    logic       prev_rd  = 1'b0;
    int         strobes  = 0;

    always @(negedge clk) begin
        if (bus.regaddr_changed === 1'b1)
            resp_idx <= 0;
        else if (prev_rd === 1'b1 && bus.zxuno_regrd === 1'b0)
            resp_idx <= resp_idx + 1;
        if (bus.zxuno_regrd === 1'b1 && prev_rd !== 1'b1)
            strobes <= strobes + 1;
        prev_rd <= bus.zxuno_regrd;
    end

    assign bus.din      = resp[resp_idx[4:0]];
    assign bus.din_oe_n = oe_n;

    int total = 0;
    int bad   = 0;
    int exp_q [$];

    typedef struct {
        int addr;
        int data;
    } rb_t;
    rb_t rb_tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < 32; i++) resp[i] = 8'h00;
        for (int i = 0; i < s.len(); i++) resp[i] = s[i];
    endtask

    task automatic load_alpha();
        for (int i = 0; i < 32; i++) resp[i] = (i < 16) ? 8'(8'h41 + i) : 8'h00;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_regrd"}, bus.zxuno_regrd, 0);
        chk({tag, "_sel"},   bus.regaddr_changed, 0);
        chk({tag, "_addr"},  bus.zxuno_addr, 0);
        chk({tag, "_len"},   len, 0);
        chk({tag, "_bufd"},  buf_data, 0);
    endtask

    task automatic readback(input int addr, input int exp);
        @(negedge clk);
        buf_addr = 4'(addr);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        chk($sformatf("buf[%0d]", addr), buf_data, exp_q.pop_front());
    endtask

    task automatic fetch(input int abort_k, input int restart_k, input int rst_k,
                         input int exp_k, input int exp_len, input int exp_err,
                         input int exp_strobes);
        int rc;
        int s0;
        int s1;
        bit fin;
        rc  = 0;
        s0  = strobes;
        fin = 1'b0;
        if (rst_k < 0) begin
            exp_q.push_back(exp_k);
            exp_q.push_back(exp_len);
            exp_q.push_back(exp_err);
            exp_q.push_back(exp_strobes);
        end
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 200 && !fin; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (bus.regaddr_changed === 1'b1) rc++;
            if (k == 1) begin
                chk("sel_pulse", bus.regaddr_changed, 1);
                chk("sel_addr", bus.zxuno_addr, c_reg_addr);
                chk("sel_len_clr", len, 0);
                chk("sel_err_clr", error, 0);
                chk("sel_done_clr", done, 0);
                chk("sel_busy", busy, 1);
            end
            if (k == 2) chk("read_strobe", bus.zxuno_regrd, 1);
            if (k == 4 && exp_k > 4) begin
                chk("gap_strobe", bus.zxuno_regrd, 0);
                chk("gap_addr", bus.zxuno_addr, c_reg_addr);
            end
            if (k == abort_k)       oe_n = 1'b1;
            if (k == abort_k + 1)   oe_n = 1'b0;
            if (k == restart_k)     start = 1'b1;
            if (k == restart_k + 1) start = 1'b0;
            if (k == rst_k)         rst = 1'b1;
            if (k == rst_k + 1) begin
                rst = 1'b0;
                fin = 1'b1;
                chk("ignored_start_sel", rc, 1);
                chk_reset("abort_rst");
                s1 = strobes;
                repeat (4) @(posedge clk);
                #1;
                chk("no_bus_after_rst", strobes - s1, 0);
                chk("idle_after_rst_busy", busy, 0);
            end else if (rst_k < 0 && done === 1'b1) begin
                fin = 1'b1;
                chk("done_cycle", k, exp_q.pop_front());
                chk("len", len, exp_q.pop_front());
                chk("error", error, exp_q.pop_front());
                chk("busy_in_done", busy, 0);
                chk("sel_once", rc, 1);
                chk("done_addr", bus.zxuno_addr, 0);
                s1 = exp_q.pop_front();
                repeat (3) @(posedge clk);
                #1;
                chk("strobes", strobes - s0, s1);
            end
        end
        if (!fin) begin
            chk("fetch_timeout", fin, 1);
            exp_q.delete();
        end
        oe_n  = 1'b0;
        start = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rb_tbl[0] = '{0,  8'h54};
        rb_tbl[1] = '{1,  8'h32};
        rb_tbl[2] = '{2,  8'h30};
        rb_tbl[3] = '{3,  8'h2D};
        rb_tbl[4] = '{5,  8'h37};
        rb_tbl[5] = '{8,  8'h32};
        rb_tbl[6] = '{11, 8'h35};
        rb_tbl[7] = '{12, 8'h00};
        rb_tbl[8] = '{15, 8'h00};

        rst      = 1'b1;
        start    = 1'b0;
        buf_addr = 4'd0;
        oe_n     = 1'b0;
        load_str("T20-07122015");
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Normal string fetch followed by table-driven read-back.
        fetch(-1, -1, -1, 52, 12, 0, 13);
        for (int i = 0; i < 9; i++) readback(rb_tbl[i].addr, rb_tbl[i].data);

        // Sixteen characters fill the buffer with no seventeenth strobe.
        load_alpha();
        fetch(-1, -1, -1, 64, 16, 0, 16);
        readback(15, 8'h50);
        readback(0, 8'h41);

        // Empty string.
        load_str("");
        fetch(-1, -1, -1, 4, 0, 0, 1);
        for (int a = 0; a < 16; a++) readback(a, 0);

        // Output enable lost during the read of byte 3.
        load_alpha();
        fetch(14, -1, -1, 15, 3, 1, 4);
        readback(2, 8'h43);
        readback(3, 8'h00);

        // Restart from DONE clears len and error.
        load_str("T20-07122015");
        fetch(-1, -1, -1, 52, 12, 0, 13);
        readback(11, 8'h35);

        // Start while busy is ignored; reset mid-fetch aborts.
        fetch(-1, 10, 20, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
